// File: rtl/serial_pkg.sv
// Shared serial-path definitions: byte width and the issue-FSM state encoding,
// common to serial_tx_fifo, serial_tx and serial_rx.
package serial_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/serial_tx_fifo_if.sv
// Host/transmitter-facing signal bundle of serial_tx_fifo.
// SERIAL_TX_FIFO_OVF_EN adds the sticky overflow flag.
interface serial_tx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [serial_pkg::BYTE_W-1:0] wr_data;
    logic                          wr_en;
    logic                          full;
    logic                          empty;
    logic [CNT_W-1:0]              count;
    logic                          block;
    logic [serial_pkg::BYTE_W-1:0] tx_data;
    logic                          new_data;
    logic                          tx_busy;
    logic                          block_tx;
`ifdef SERIAL_TX_FIFO_OVF_EN
    logic                          overflow;

    modport master (
        output wr_data, wr_en, block, tx_busy,
        input  full, empty, count, tx_data, new_data, block_tx, overflow
    );
    modport slave (
        input  wr_data, wr_en, block, tx_busy,
        output full, empty, count, tx_data, new_data, block_tx, overflow
    );
`else
    modport master (
        output wr_data, wr_en, block, tx_busy,
        input  full, empty, count, tx_data, new_data, block_tx
    );
    modport slave (
        input  wr_data, wr_en, block, tx_busy,
        output full, empty, count, tx_data, new_data, block_tx
    );
`endif

endinterface

// File: rtl/byte_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read at the read pointer.
module byte_fifo_mem
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  byte_t                wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output byte_t                rd_data_c
);

    byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding serial_tx: issues one new_data pulse per byte while the
// transmitter is idle and unblocked. SERIAL_TX_FIFO_OVF_EN adds a sticky overflow flag.
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    serial_tx_fifo_if.slave   bus
);

    localparam int unsigned ADDR_SIZE = $clog2(DEPTH);
    localparam int unsigned CNT_W     = ADDR_SIZE + 1;

    tx_state_e            state_q,    state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]     count_q,    count_d;
    logic                 full_q,     full_d;
    logic                 empty_q,    empty_d;
    byte_t                tx_data_q,  tx_data_d;
    logic                 new_data_q, new_data_d;
    logic                 block_tx_q, block_tx_d;
`ifdef SERIAL_TX_FIFO_OVF_EN
    logic                 overflow_q, overflow_d;
`endif

    logic  wr_ok_c;
    logic  issue_c;
    byte_t rd_data_c;

    byte_fifo_mem #(
        .DEPTH     (DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_ok_c),
        .wr_addr   (wr_ptr_q),
        .wr_data   (bus.wr_data),
        .rd_addr   (rd_ptr_q),
        .rd_data_c (rd_data_c)
    );

    // Issue only when serial_tx is idle and its own block register is guaranteed low.
    always_comb begin
        wr_ok_c    = bus.wr_en && !full_q;
        issue_c    = (state_q == IDLE) && !empty_q && !bus.tx_busy
                     && !bus.block && !block_tx_q;

        state_d    = state_q;
        tx_data_d  = tx_data_q;
        new_data_d = 1'b0;
        block_tx_d = bus.block;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef SERIAL_TX_FIFO_OVF_EN
        overflow_d = overflow_q || (bus.wr_en && full_q);
`endif

        case (state_q)
            IDLE: begin
                if (issue_c) begin
                    state_d    = HOLD;
                    tx_data_d  = rd_data_c;
                    new_data_d = 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_ok_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
        if (issue_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
        end

        case ({wr_ok_c, issue_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_data_q  <= '0;
            new_data_q <= 1'b0;
            block_tx_q <= 1'b0;
`ifdef SERIAL_TX_FIFO_OVF_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_data_q  <= tx_data_d;
            new_data_q <= new_data_d;
            block_tx_q <= block_tx_d;
`ifdef SERIAL_TX_FIFO_OVF_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.new_data = new_data_q;
    assign bus.block_tx = block_tx_q;
`ifdef SERIAL_TX_FIFO_OVF_EN
    assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench for serial_tx_fifo with a behavioural serial_tx busy model.
`timescale 1ns/1ps
module tb_serial_tx_fifo;
    import serial_pkg::*;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned CLK_PER_BIT = 4;
    localparam int unsigned FRAME_CYC   = 10 * CLK_PER_BIT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    logic use_model  = 1'b0;
    logic busy_force = 1'b0;
    logic m_busy;
    logic m_blk;
    int unsigned m_cnt;
    int m_frames = 0;
    int m_lost   = 0;

    assign bus.tx_busy = use_model ? m_busy : busy_force;

    serial_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    logic prev_nd = 1'b0;
    byte_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // serial_tx stand-in: 10-bit frame, ignores pulses while busy or blocked
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_blk  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_blk <= bus.block_tx;
            if (use_model && bus.new_data && !m_busy && !m_blk) begin
                m_busy   <= 1'b1;
                m_cnt    <= FRAME_CYC - 1;
                m_frames <= m_frames + 1;
            end else begin
                if (use_model && bus.new_data) m_lost <= m_lost + 1;
                if (m_busy) begin
                    if (m_cnt == 0) m_busy <= 1'b0;
                    else            m_cnt  <= m_cnt - 1;
                end
            end
        end
    end

    // Monitor: every pulse pops the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_nd = 1'b0;
        end else begin
            if (bus.new_data) begin
                pulses++;
                chk("pulse_spacing", 32'(prev_nd), 32'd0);
                chk("pulse_while_busy", 32'(bus.tx_busy), 32'd0);
                chk("unexpected_pulse", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(sbq.pop_front()));
            end
            prev_nd = bus.new_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input byte_t d, input bit accepted);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        if (accepted) sbq.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.empty && !bus.new_data && !(use_model && m_busy)) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int f0;
        bus.wr_data = '0;
        bus.wr_en   = 1'b0;
        bus.block   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_new_data", 32'(bus.new_data), 32'd0);
        chk("rst_block_tx", 32'(bus.block_tx), 32'd0);
`ifdef SERIAL_TX_FIFO_OVF_EN
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        tick();
        rst = 1'b0;

        // single byte: pulse two cycles after wr_en
        bus.wr_data = 8'hA5;
        bus.wr_en   = 1'b1;
        sbq.push_back(8'hA5);
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("t1_count1", 32'(bus.count), 32'd1);
        chk("t1_nd_early", 32'(bus.new_data), 32'd0);
        chk("t1_empty0", 32'(bus.empty), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_pulse", 32'(bus.new_data), 32'd1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("t1_count0", 32'(bus.count), 32'd0);
        chk("t1_empty1", 32'(bus.empty), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_pulse_end", 32'(bus.new_data), 32'd0);
        chk("t1_tx_hold", 32'(bus.tx_data), 32'hA5);

        // fill to DEPTH, then one dropped write
        tick();
        busy_force = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(byte_t'(i), 1'b1);
        write_byte(8'h11, 1'b0);
        @(negedge clk);
        chk("t2_full", 32'(bus.full), 32'd1);
        chk("t2_count", 32'(bus.count), 32'd16);
        chk("t2_empty", 32'(bus.empty), 32'd0);
`ifdef SERIAL_TX_FIFO_OVF_EN
        chk("t2_overflow", 32'(bus.overflow), 32'd1);
`endif
        busy_force = 1'b0;
        wait_drain(100);
        chk("t2_count_end", 32'(bus.count), 32'd0);

        // three frames through the serial_tx model
        use_model = 1'b1;
        f0 = m_frames;
        write_byte(8'h55, 1'b1);
        write_byte(8'hAA, 1'b1);
        write_byte(8'h0F, 1'b1);
        wait_drain(400);
        chk("t3_frames", 32'(m_frames - f0), 32'd3);
        chk("t3_lost", 32'(m_lost), 32'd0);
        use_model = 1'b0;

        // block holds two queued bytes; block_tx lags by one cycle
        tick();
        bus.block = 1'b1;
        @(negedge clk);
        chk("t4_btx_lag_hi", 32'(bus.block_tx), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_btx_hi", 32'(bus.block_tx), 32'd1);
        tick();
        p0 = pulses;
        write_byte(8'hC1, 1'b1);
        write_byte(8'hC2, 1'b1);
        repeat (46) tick();
        chk("t4_no_pulse", 32'(pulses - p0), 32'd0);
        chk("t4_count", 32'(bus.count), 32'd2);
        bus.block = 1'b0;
        @(negedge clk);
        chk("t4_btx_lag_lo", 32'(bus.block_tx), 32'd1);
        tick();
        @(negedge clk);
        chk("t4_btx_lo", 32'(bus.block_tx), 32'd0);
        repeat (4) tick();
        @(negedge clk);
        chk("t4_two_pulses", 32'(pulses - p0), 32'd2);

        // write coinciding with a pop at count=5
        tick();
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(byte_t'(8'h21 + i), 1'b1);
        @(negedge clk);
        chk("t5_count5", 32'(bus.count), 32'd5);
        bus.wr_data = 8'h3C;
        bus.wr_en   = 1'b1;
        sbq.push_back(8'h3C);
        busy_force  = 1'b0;
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("t5_pop_pulse", 32'(bus.new_data), 32'd1);
        chk("t5_count_same", 32'(bus.count), 32'd5);
        #1;
        busy_force = 1'b1;
        repeat (3) tick();
        chk("t5_count_hold", 32'(bus.count), 32'd5);
        busy_force = 1'b0;
        wait_drain(100);
        // 20 streaming bytes carry both pointers around the ring
        for (int i = 0; i < 20; i++) write_byte(byte_t'(8'h80 + i), 1'b1);
        wait_drain(100);
        chk("t5_wrap_empty", 32'(bus.empty), 32'd1);
        chk("t5_wrap_count", 32'(bus.count), 32'd0);
`ifdef SERIAL_TX_FIFO_OVF_EN
        chk("t5_overflow_sticky", 32'(bus.overflow), 32'd1);
`endif

        // reset during HOLD with count=3
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(byte_t'(8'h61 + i), 1'b1);
        @(negedge clk);
        chk("t6_count4", 32'(bus.count), 32'd4);
        busy_force = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_issue", 32'(bus.new_data), 32'd1);
        chk("t6_count3", 32'(bus.count), 32'd3);
        tick();
        @(negedge clk);
        chk("t6_rst_nd", 32'(bus.new_data), 32'd0);
        chk("t6_rst_count", 32'(bus.count), 32'd0);
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
`ifdef SERIAL_TX_FIFO_OVF_EN
        chk("t6_rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        sbq.delete();
        rst = 1'b0;
        p0 = pulses;
        repeat (20) tick();
        chk("t6_no_pulse", 32'(pulses - p0), 32'd0);

        chk("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
